// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared state encoding and limits for the clock-divider controller
package clkdiv_pkg;
  typedef enum logic [1:0] {IDLE, RUN, STOP} state_e;
  localparam int MIN_DIV = 2;
endpackage

// File: rtl/clkdiv_if.sv
// clkdiv_if: ratio configuration handshake between config logic and the divider
interface clkdiv_if #(parameter int DIV_W = 8);
  logic             cfg_valid;
  logic [DIV_W-1:0] cfg_div;
  logic             cfg_ready;
  logic             cfg_err;
  modport master (output cfg_valid, cfg_div, input cfg_ready, cfg_err);
  modport slave  (input cfg_valid, cfg_div, output cfg_ready, cfg_err);
endinterface

// File: rtl/clkdiv_core.sv
// clkdiv_core: period counter, wrap detect and registered clkout/clk_tick
module clkdiv_core #(
  parameter int DIV_W = 8
) (
  input  logic             clkin,
  input  logic             rstn,
  input  logic             run,
  input  logic [DIV_W-1:0] div,
  input  logic             load_zero,
  output logic             wrap,
  output logic             clkout,
  output logic             clk_tick
);
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             clkout_q, clkout_d;
  logic             clk_tick_q, clk_tick_d;
  always_comb begin
    wrap       = run && (cnt_q == div - 1'b1);
    cnt_d      = (!run || wrap || load_zero) ? '0 : cnt_q + 1'b1;
    clkout_d   = run && (cnt_q >= (div >> 1));
    clk_tick_d = clkout_d && !clkout_q;
  end
  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      cnt_q      <= '0;
      clkout_q   <= 1'b0;
      clk_tick_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      clkout_q   <= clkout_d;
      clk_tick_q <= clk_tick_d;
    end
  end
  assign clkout   = clkout_q;
  assign clk_tick = clk_tick_q;
endmodule

// File: rtl/clkdiv_ctrl.sv
// clkdiv_ctrl: run/stop FSM, ratio handshake and boundary-aligned ratio updates
module clkdiv_ctrl
  import clkdiv_pkg::*;
#(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clkin,
  input  logic             rstn,
  input  logic             enable,
  clkdiv_if.slave          cfg,
  output logic             clkout,
  output logic             clk_tick,
  output logic [DIV_W-1:0] cur_div,
  output logic             busy
);
  state_e           state_q, state_d;
  logic             pending_q, pending_d;
  logic [DIV_W-1:0] pend_div_q, pend_div_d;
  logic [DIV_W-1:0] cur_div_q, cur_div_d;
  logic             cfg_err_q, cfg_err_d;
  logic             run, xfer, legal, wrap, load_zero;
  always_comb begin
    run        = state_q != IDLE;
    xfer       = cfg.cfg_valid && !pending_q;
    legal      = cfg.cfg_div >= DIV_W'(MIN_DIV);
    load_zero  = wrap && pending_q;
    cfg_err_d  = xfer && !legal;
    state_d    = state_q == IDLE ? (enable ? RUN : IDLE) :
                 state_q == RUN  ? (enable ? RUN : STOP) :
                                   (wrap ? IDLE : STOP);
    pending_d  = (xfer && legal && run) ? 1'b1 : (wrap ? 1'b0 : pending_q);
    pend_div_d = (xfer && legal && run) ? cfg.cfg_div : pend_div_q;
    cur_div_d  = (xfer && legal && !run) ? cfg.cfg_div :
                 load_zero                ? pend_div_q  : cur_div_q;
  end
  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      pending_q  <= 1'b0;
      pend_div_q <= '0;
      cur_div_q  <= DIV_W'(DEFAULT_DIV);
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      pend_div_q <= pend_div_d;
      cur_div_q  <= cur_div_d;
      cfg_err_q  <= cfg_err_d;
    end
  end
  clkdiv_core #(.DIV_W(DIV_W)) u_core (
    .clkin     (clkin),
    .rstn      (rstn),
    .run       (run),
    .div       (cur_div_q),
    .load_zero (load_zero),
    .wrap      (wrap),
    .clkout    (clkout),
    .clk_tick  (clk_tick)
  );
  assign cfg.cfg_ready = !pending_q;
  assign cfg.cfg_err   = cfg_err_q;
  assign cur_div       = cur_div_q;
  assign busy          = run;
endmodule

// File: tb/tb_clkdiv_ctrl.sv
// tb_clkdiv_ctrl: table, directed and random checks against a period-queue reference model
module tb_clkdiv_ctrl;
  localparam int DIV_W = 8;
  localparam int DEFAULT_DIV = 2;

  logic clkin = 1'b0;
  logic rstn = 1'b0;
  logic enable = 1'b0;
  logic clkout, clk_tick, busy;
  logic [DIV_W-1:0] cur_div;

  always #5 clkin = ~clkin;

  clkdiv_if #(.DIV_W(DIV_W)) cfg ();

  clkdiv_ctrl #(.DIV_W(DIV_W), .DEFAULT_DIV(DEFAULT_DIV)) dut (
    .clkin    (clkin),
    .rstn     (rstn),
    .enable   (enable),
    .cfg      (cfg),
    .clkout   (clkout),
    .clk_tick (clk_tick),
    .cur_div  (cur_div),
    .busy     (busy)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each period is a queue of floor(N/2) lows then ceil(N/2) highs
  int m_st;
  bit q[$];
  int m_cur;
  bit m_pv;
  int m_pd;
  bit m_clk, m_tick, m_err;

  task automatic m_reset();
    m_st = 0;
    q.delete();
    m_cur = DEFAULT_DIV;
    m_pv = 0;
    m_pd = 0;
    m_clk = 0;
    m_tick = 0;
    m_err = 0;
  endtask

  task automatic m_step();
    bit run, wrap, nclk, xfer, legal;
    run = m_st != 0;
    wrap = 0;
    nclk = 0;
    xfer = cfg.cfg_valid && !m_pv;
    legal = cfg.cfg_div >= 2;
    if (run) begin
      if (q.size() == 0) begin
        repeat (m_cur / 2) q.push_back(1'b0);
        repeat (m_cur - m_cur / 2) q.push_back(1'b1);
      end
      nclk = q.pop_front();
      wrap = q.size() == 0;
    end
    m_tick = nclk && !m_clk;
    m_clk = nclk;
    m_err = xfer && !legal;
    if (wrap && m_pv) begin
      m_cur = m_pd;
      m_pv = 0;
    end
    if (xfer && legal) begin
      if (run) begin
        m_pv = 1;
        m_pd = int'(cfg.cfg_div);
      end else m_cur = int'(cfg.cfg_div);
    end
    m_st = m_st == 0 ? (enable ? 1 : 0) : m_st == 1 ? (enable ? 1 : 2) : (wrap ? 0 : 2);
  endtask

  task automatic m_check();
    chk("clkout", clkout, m_clk);
    chk("clk_tick", clk_tick, m_tick);
    chk("cfg_ready", cfg.cfg_ready, !m_pv);
    chk("cfg_err", cfg.cfg_err, m_err);
    chk("cur_div", cur_div, m_cur);
    chk("busy", busy, m_st != 0);
  endtask

  task automatic cycle();
    @(posedge clkin);
    m_step();
    @(negedge clkin);
    m_check();
  endtask

  task automatic send(input int d);
    cfg.cfg_valid = 1'b1;
    cfg.cfg_div = DIV_W'(d);
    cycle();
    cfg.cfg_valid = 1'b0;
  endtask

  task automatic wait_edge(input bit rise, input string tag);
    int n = 0;
    bit prev = clkout;
    while (!(clkout == rise && prev != rise) && n < 64) begin
      prev = clkout;
      cycle();
      n++;
    end
    chk(tag, n < 64, 1);
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!cfg.cfg_ready && n < 64) begin
      cycle();
      n++;
    end
    chk(tag, cfg.cfg_ready, 1);
  endtask

  task automatic measure(input int lo, input int hi, input string tag);
    int h = 0;
    int l = 0;
    wait_edge(1'b1, {tag, " rise"});
    while (clkout && h < 64) begin
      h++;
      cycle();
    end
    while (!clkout && l < 64) begin
      l++;
      cycle();
    end
    chk({tag, " high"}, h, hi);
    chk({tag, " low"}, l, lo);
  endtask

  typedef struct {
    bit en;
    bit v;
    int d;
    bit clk;
    bit tick;
    bit err;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int n;
    tbl = '{'{1, 0, 0, 0, 0, 0}, '{1, 0, 0, 0, 0, 0}, '{1, 0, 0, 1, 1, 0},
            '{1, 0, 0, 0, 0, 0}, '{1, 0, 0, 1, 1, 0}, '{1, 0, 0, 0, 0, 0},
            '{1, 1, 1, 1, 1, 1}, '{1, 1, 0, 0, 0, 1}, '{1, 0, 0, 1, 1, 0}};
    cfg.cfg_valid = 1'b0;
    cfg.cfg_div = '0;
    m_reset();
    repeat (2) @(negedge clkin);
    chk("rst clkout", clkout, 0);
    chk("rst tick", clk_tick, 0);
    chk("rst ready", cfg.cfg_ready, 1);
    chk("rst err", cfg.cfg_err, 0);
    chk("rst cur_div", cur_div, DEFAULT_DIV);
    chk("rst busy", busy, 0);
    rstn = 1'b1;

    for (int i = 0; i < 9; i++) begin
      enable = tbl[i].en;
      cfg.cfg_valid = tbl[i].v;
      cfg.cfg_div = DIV_W'(tbl[i].d);
      cycle();
      chk($sformatf("tbl%0d clkout", i), clkout, tbl[i].clk);
      chk($sformatf("tbl%0d tick", i), clk_tick, tbl[i].tick);
      chk($sformatf("tbl%0d err", i), cfg.cfg_err, tbl[i].err);
      chk($sformatf("tbl%0d cur_div", i), cur_div, DEFAULT_DIV);
      chk($sformatf("tbl%0d busy", i), busy, 1);
      chk($sformatf("tbl%0d ready", i), cfg.cfg_ready, 1);
    end
    cfg.cfg_valid = 1'b0;

    enable = 1'b0;
    n = 0;
    while (busy && n < 32) begin
      cycle();
      n++;
    end
    chk("n2 stopped", busy, 0);
    send(5);
    chk("idle cfg cur_div", cur_div, 5);
    enable = 1'b1;
    measure(2, 3, "n5");

    send(4);
    chk("n4 ready low", cfg.cfg_ready, 0);
    repeat (12) cycle();
    measure(2, 2, "n4");
    send(7);
    chk("n7 ready low", cfg.cfg_ready, 0);
    wait_ready("n7 ready back");
    measure(3, 4, "n7");

    send(6);
    wait_ready("n6 ready back");
    repeat (4) cycle();
    wait_edge(1'b0, "n6 fall");
    enable = 1'b0;
    n = 0;
    do begin
      cycle();
      n++;
    end while (busy && n < 20);
    chk("stop length", n, 5);
    cycle();
    chk("idle clkout", clkout, 0);

    enable = 1'b1;
    repeat (10) cycle();
    wait_edge(1'b0, "n6 fall2");
    enable = 1'b0;
    cycle();
    cycle();
    chk("stop busy", busy, 1);
    enable = 1'b1;
    n = 0;
    do begin
      cycle();
      n++;
    end while (busy && n < 20);
    chk("stop ignores enable", n, 3);
    cycle();
    chk("rerun busy", busy, 1);

    repeat (8) cycle();
    wait_edge(1'b1, "n6 rise");
    send(3);
    chk("pend ready low", cfg.cfg_ready, 0);
    chk("pend clkout high", clkout, 1);
    #2 rstn = 1'b0;
    #1;
    chk("arst clkout", clkout, 0);
    chk("arst tick", clk_tick, 0);
    chk("arst ready", cfg.cfg_ready, 1);
    chk("arst err", cfg.cfg_err, 0);
    chk("arst cur_div", cur_div, DEFAULT_DIV);
    chk("arst busy", busy, 0);
    @(negedge clkin);
    rstn = 1'b1;
    m_reset();
    cycle();
    chk("post rst cur_div", cur_div, DEFAULT_DIV);

    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(15) == 0) enable = ~enable;
      cfg.cfg_valid = $urandom_range(7) == 0;
      cfg.cfg_div = DIV_W'($urandom_range(9));
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/clkdiv_ctrl.md
# clkdiv_ctrl

Runtime-programmable clock-divider controller: it sequences a counter-based divide-by-N generator, accepts new ratios over a valid/ready handshake, and applies them only at period boundaries so clkout never produces a runt pulse. It sits between the configuration logic and every consumer of a divided clock or clock-enable. It also gates the divider on and off cleanly, and reports the active ratio and status.

## Interface
- DIV_W, 8: width of the ratio fields.
- DEFAULT_DIV, 2: ratio loaded at reset. Must be ≥2 and <2^DIV_W.
- clkin  in  1  system clock; all logic is on the rising edge.
- rstn  in  1  reset, asynchronous and active-low.
- enable  in  1  level request to run the divider.
- cfg_valid  in  1  new-ratio request.
- cfg_div  in  DIV_W  requested ratio N.
- cfg_ready  out  1  controller can accept a ratio.
- cfg_err  out  1  one-cycle pulse when an illegal ratio (N<2) is accepted.
- clkout  out  1  divided output, registered.
- clk_tick  out  1  one-cycle pulse, registered alongside the clkout rising edge.
- cur_div  out  DIV_W  ratio currently in force.
- busy  out  1  high in RUN or STOP.

## Operation
- Reset values: state IDLE, cnt 0, clkout 0, clk_tick 0, cfg_ready 1, cfg_err 0, cur_div DEFAULT_DIV, pending flag 0, busy 0.
- States:
  - IDLE: cnt held at 0, clkout 0.
  - RUN: dividing.
  - STOP: finishing the current period after enable drops.
- Transitions:
  - IDLE→RUN when enable is 1. cnt is 0 on the first RUN cycle.
  - RUN→STOP when enable is 0.
  - STOP→IDLE at a wrap.
  - enable is ignored while in STOP. If enable is still 1 when IDLE is reached, RUN is re-entered on the next edge.
- Counter: in RUN and STOP, cnt counts 0..cur_div−1 and then wraps to 0. A "wrap" is the cycle in which cnt==cur_div−1.
- Duty: clkout(t+1) = (state∈{RUN,STOP}) && cnt(t) ≥ cur_div>>1.
  - Low phase is floor(N/2) cycles; high phase is ceil(N/2) cycles.
  - Odd N gives the extra cycle to the high phase.
- clk_tick(t+1) = 1 exactly when clkout goes 0→1 at t+1.
- Config handshake: a transfer occurs when cfg_valid && cfg_ready. cfg_ready = !pending.
  - cfg_div<2: the transfer is accepted, cfg_err pulses on the next cycle, and nothing else changes.
  - Legal N in IDLE: cur_div takes N on the next edge.
  - Legal N in RUN or STOP: N is latched and pending is set. At the next wrap, cur_div takes N, cnt goes to 0, and pending clears.
- Simultaneous events:
  - A transfer in the same cycle as a wrap is applied at the following wrap, not the current one.
  - enable falling together with a pending ratio: the ratio is still applied at the STOP wrap.
  - Changing the ratio and stopping in the same period both complete at that wrap.
- Reset mid-operation: all state returns to reset values immediately. Any pending ratio is discarded.

## Timing
- Latency from enable rising in IDLE to the first clkout edge: RUN is entered at edge+1, and clkout rises at edge+1+floor(N/2)+1.
- N=2 gives clkout 0,1,0,1,… and one clk_tick per two clkin cycles.
- A ratio change takes effect at cnt reset at the wrap. The first new period then starts with floor(Nnew/2) low cycles.
- Stop: the last high phase completes fully. clkout is 0 from the cycle after the STOP wrap.
- cfg_ready drops on the cycle after a legal transfer in RUN/STOP and rises on the cycle after the applying wrap.

## Structure
- Shared package clkdiv_pkg holds:
  - the state encoding (IDLE, RUN, STOP);
  - MIN_DIV=2.
- Sub-module clkdiv_core holds the cnt register, the wrap detect, and the duty compare/clkout/clk_tick registers. It takes run, div and load_zero as inputs.
- clkdiv_ctrl holds the FSM, the handshake, the pending register and cur_div.

## Test plan
- Reset with DEFAULT_DIV=2, enable=1: clkout toggles every cycle after the 2-cycle latency, clk_tick matches its rising edges, and busy=1.
- Send cfg_div=5 in IDLE, then enable: clkout is low 2 cycles and high 3 cycles, repeating, and cur_div=5.
- While running at N=4, send cfg_div=7 mid-period:
  - cfg_ready is low until the wrap;
  - the current 4-cycle period completes intact;
  - the next periods are 3 low / 4 high.
- Send cfg_div=1 and then cfg_div=0: each gives a cfg_err pulse of one cycle, cur_div is unchanged, and the output is undisturbed.
- At N=6, drop enable at cnt=1:
  - the state goes to STOP and the period finishes;
  - clkout is 0 and the state is IDLE after the wrap;
  - re-raising enable during STOP is ignored until IDLE is reached.
- Assert rstn low mid-high-phase with a ratio pending: all outputs go to reset values asynchronously, and after release cur_div=DEFAULT_DIV.
